// File: rtl/ballot_counter_n.sv
// rtl/ballot_counter_n.sv - parametrised debounced ballot unit with tallies, winner detect and results display
//
// Purpose:
//   N_CAND debounced candidate buttons feed a one-vote-per-voter ballot FSM
//   (IDLE -> ARMED -> ACK). Accepted votes bump saturating per-candidate tallies.
//   A registered winner/tie detector tracks the current leader. In results mode
//   a button press selects which tally is shown on the LED bus.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_mode         0 = voting, 1 = results
//   i_voter_enable poll-worker arm request, sampled in IDLE
//   i_button       raw candidate buttons [N_CAND]
//   o_led          LED display [LED_W]
//   o_armed        ballot armed, waiting for a vote
//   o_reject       one-cycle pulse when a valid press is discarded
//   o_winner       index of the highest tally (lowest index on equality)
//   o_tie          two or more candidates share the highest tally
//   o_overflow     sticky: a vote arrived at a saturated tally

module ballot_counter_n #(
    parameter int N_CAND     = 4,
    parameter int CNT_W      = 8,
    parameter int DEBOUNCE   = 10,
    parameter int ACK_CYCLES = 4,
    parameter int LED_W      = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_mode,
    input  logic                      i_voter_enable,
    input  logic [N_CAND-1:0]         i_button,
    output logic [LED_W-1:0]          o_led,
    output logic                      o_armed,
    output logic                      o_reject,
    output logic [$clog2(N_CAND)-1:0] o_winner,
    output logic                      o_tie,
    output logic                      o_overflow
);

    localparam int SEL_W = $clog2(N_CAND);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int ACK_W = $clog2(ACK_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Debouncers: one counter per channel. The valid pulse fires only on
    // the DEBOUNCE-1 -> DEBOUNCE step, so a held button cannot re-fire.
    // ------------------------------------------------------------------
    logic [DB_W-1:0]   r_db_cnt [N_CAND];
    logic [N_CAND-1:0] r_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_CAND; i++) begin
                r_db_cnt[i] <= '0;
            end
            r_valid <= '0;
        end else begin
            for (int i = 0; i < N_CAND; i++) begin
                if (!i_button[i]) begin
                    r_db_cnt[i] <= '0;
                    r_valid[i]  <= 1'b0;
                end else if (r_db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                    r_db_cnt[i] <= DB_W'(DEBOUNCE);
                    r_valid[i]  <= 1'b1;
                end else begin
                    if (r_db_cnt[i] != DB_W'(DEBOUNCE)) begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                    end
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Fixed-priority arbiter: lowest index wins; w_multi flags that at
    // least one other channel was dropped in the same cycle.
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] w_grant_idx;
    logic             w_any;
    logic             w_multi;

    always_comb begin
        w_grant_idx = '0;
        w_any       = 1'b0;
        for (int i = N_CAND - 1; i >= 0; i--) begin
            if (r_valid[i]) begin
                w_grant_idx = SEL_W'(i);
                w_any       = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(r_valid & (r_valid - N_CAND'(1)));

    // ------------------------------------------------------------------
    // Ballot FSM state and registered outputs
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [ACK_W-1:0] r_ack_cnt;
    logic             r_armed;
    logic             r_reject;
    logic [LED_W-1:0] r_led;
    logic [SEL_W-1:0] r_sel;

    logic [CNT_W-1:0] r_tally [N_CAND];
    logic             r_overflow;

    logic             w_vote;
    logic             w_ack_next;
    logic [SEL_W-1:0] w_sel_next;
    logic [LED_W-1:0] w_disp;

    // A vote is counted only from ARMED in voting mode; mode=1 cancels first.
    assign w_vote = (r_state == S_ARMED) && !i_mode && w_any;

    // LED shows all ones whenever the FSM will be in ACK after this edge.
    assign w_ack_next = w_vote || ((r_state == S_ACK) && (r_ack_cnt != '0));

    // In results mode a press selects the displayed tally on the same edge
    // the display is reloaded, so the new value appears one edge after the pulse.
    assign w_sel_next = (i_mode && w_any) ? w_grant_idx : r_sel;

    always_comb begin
        w_disp = '0;
        for (int b = 0; b < LED_W && b < CNT_W; b++) begin
            w_disp[b] = r_tally[w_sel_next][b];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ack_cnt <= '0;
            r_armed   <= 1'b0;
            r_reject  <= 1'b0;
            r_led     <= '0;
            r_sel     <= '0;
        end else begin
            r_reject <= 1'b0;
            r_sel    <= w_sel_next;

            case (r_state)
                S_IDLE: begin
                    if (!i_mode && w_any) begin
                        r_reject <= 1'b1;
                    end
                    if (i_voter_enable && !i_mode) begin
                        r_state <= S_ARMED;
                        r_armed <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (i_mode) begin
                        r_state <= S_IDLE;
                        r_armed <= 1'b0;
                    end else if (w_any) begin
                        r_state   <= S_ACK;
                        r_armed   <= 1'b0;
                        r_ack_cnt <= ACK_W'(ACK_CYCLES - 1);
                        r_reject  <= w_multi;
                    end
                end
                S_ACK: begin
                    if (!i_mode && w_any) begin
                        r_reject <= 1'b1;
                    end
                    if (r_ack_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt - ACK_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_armed <= 1'b0;
                end
            endcase

            if (i_mode) begin
                r_led <= w_disp;
            end else if (w_ack_next) begin
                r_led <= '1;
            end else begin
                r_led <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating tallies; overflow is sticky until reset.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_CAND; i++) begin
                r_tally[i] <= '0;
            end
            r_overflow <= 1'b0;
        end else if (w_vote) begin
            if (r_tally[w_grant_idx] == {CNT_W{1'b1}}) begin
                r_overflow <= 1'b1;
            end else begin
                r_tally[w_grant_idx] <= r_tally[w_grant_idx] + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Winner / tie detection, registered one cycle behind the tallies.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_max;
    logic [SEL_W-1:0] w_max_idx;
    logic             w_seen;
    logic             w_tie;
    logic [SEL_W-1:0] r_winner;
    logic             r_tie;

    always_comb begin
        w_max     = r_tally[0];
        w_max_idx = '0;
        for (int i = 1; i < N_CAND; i++) begin
            if (r_tally[i] > w_max) begin
                w_max     = r_tally[i];
                w_max_idx = SEL_W'(i);
            end
        end
        w_seen = 1'b0;
        w_tie  = 1'b0;
        for (int i = 0; i < N_CAND; i++) begin
            if (r_tally[i] == w_max) begin
                if (w_seen) begin
                    w_tie = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_winner <= '0;
            r_tie    <= 1'b1;
        end else begin
            r_winner <= w_max_idx;
            r_tie    <= w_tie;
        end
    end

    assign o_led      = r_led;
    assign o_armed    = r_armed;
    assign o_reject   = r_reject;
    assign o_winner   = r_winner;
    assign o_tie      = r_tie;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_ballot_counter_n.sv
// tb/tb_ballot_counter_n.sv - scoreboard bench for ballot_counter_n

module tb_ballot_counter_n;

    localparam int EV_VOTE = 0;
    localparam int EV_REJ  = 1;

    localparam int F_LED   = 0;
    localparam int F_ARMED = 1;
    localparam int F_WIN   = 2;
    localparam int F_TIE   = 3;
    localparam int F_OV    = 4;
    localparam int S_LED   = 5;
    localparam int S_OV    = 6;
    localparam int S_WIN   = 7;
    localparam int S_TIE   = 8;

    typedef struct {
        string nm;
        int    fld;
        int    exp;
    } snap_t;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       ven;
    logic [3:0] button;
    logic [7:0] o_led;
    logic       o_armed;
    logic       o_reject;
    logic [1:0] o_winner;
    logic       o_tie;
    logic       o_overflow;

    logic       s_mode;
    logic       s_ven;
    logic [3:0] s_button;
    logic [7:0] s_led;
    logic       s_armed;
    logic       s_reject;
    logic [1:0] s_winner;
    logic       s_tie;
    logic       s_ov;

    int    checks;
    int    errors;
    int    cyc;
    int    run;
    logic  prev_ones;
    logic  ones;
    logic  done;
    int    evq[$];
    snap_t snapq[$];

    ballot_counter_n #(
        .N_CAND(4), .CNT_W(8), .DEBOUNCE(10), .ACK_CYCLES(4), .LED_W(8)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_voter_enable(ven),
        .i_button(button), .o_led(o_led), .o_armed(o_armed), .o_reject(o_reject),
        .o_winner(o_winner), .o_tie(o_tie), .o_overflow(o_overflow)
    );

    ballot_counter_n #(
        .N_CAND(4), .CNT_W(2), .DEBOUNCE(3), .ACK_CYCLES(2), .LED_W(8)
    ) u_sat (
        .i_clk(clk), .i_rst(rst), .i_mode(s_mode), .i_voter_enable(s_ven),
        .i_button(s_button), .o_led(s_led), .o_armed(s_armed), .o_reject(s_reject),
        .o_winner(s_winner), .o_tie(s_tie), .o_overflow(s_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int actual(input int f);
        case (f)
            F_LED:   return int'(o_led);
            F_ARMED: return int'(o_armed);
            F_WIN:   return int'(o_winner);
            F_TIE:   return int'(o_tie);
            F_OV:    return int'(o_overflow);
            S_LED:   return int'(s_led);
            S_OV:    return int'(s_ov);
            S_WIN:   return int'(s_winner);
            S_TIE:   return int'(s_tie);
            default: return -1;
        endcase
    endfunction

    // Monitor: compares every queued expectation against what the DUT presents.
    always @(negedge clk) begin
        snap_t s;
        cyc++;
        while (snapq.size() > 0) begin
            s = snapq.pop_front();
            check(s.nm, actual(s.fld), s.exp);
        end
        if (rst) begin
            run       = 0;
            prev_ones = 1'b0;
        end else begin
            if (o_reject) begin
                check("reject_expected", (evq.size() > 0 && evq[0] == EV_REJ) ? 1 : 0, 1);
                if (evq.size() > 0) void'(evq.pop_front());
            end
            ones = (o_led == 8'hFF) && !mode;
            if (ones && !prev_ones) begin
                check("vote_expected", (evq.size() > 0 && evq[0] == EV_VOTE) ? 1 : 0, 1);
                if (evq.size() > 0) void'(evq.pop_front());
                check("armed_in_ack", int'(o_armed), 0);
            end
            if (ones) begin
                run++;
            end else if (prev_ones) begin
                check("ack_len", run, 4);
                run = 0;
            end
            prev_ones = ones;
        end
        if (done || cyc > 20000) begin
            check("timeout", (cyc > 20000) ? 1 : 0, 0);
            check("events_pending", evq.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic expect_val(input string nm, input int f, input int v);
        snap_t s;
        s.nm  = nm;
        s.fld = f;
        s.exp = v;
        snapq.push_back(s);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm(input int d);
        @(posedge clk); #1;
        if (d == 0) ven = 1'b1; else s_ven = 1'b1;
        @(posedge clk); #1;
        ven   = 1'b0;
        s_ven = 1'b0;
    endtask

    task automatic press(input int d, input logic [3:0] m, input int n);
        if (d == 0) button = m; else s_button = m;
        repeat (n) @(posedge clk);
        #1;
        button   = '0;
        s_button = '0;
    endtask

    task automatic vote(input logic [3:0] m);
        arm(0);
        evq.push_back(EV_VOTE);
        press(0, m, 12);
        idle(6);
    endtask

    task automatic s_vote();
        arm(1);
        press(1, 4'b0001, 5);
        idle(4);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; run = 0;
        prev_ones = 1'b0; ones = 1'b0; done = 1'b0;
        rst = 1'b1; mode = 1'b0; ven = 1'b0; button = '0;
        s_mode = 1'b0; s_ven = 1'b0; s_button = '0;
        idle(3);
        rst = 1'b0;
        idle(1);
        expect_val("rst_led", F_LED, 0);
        expect_val("rst_armed", F_ARMED, 0);
        expect_val("rst_winner", F_WIN, 0);
        expect_val("rst_tie", F_TIE, 1);
        expect_val("rst_overflow", F_OV, 0);

        // Armed vote on candidate 2, held 15 cycles -> exactly one vote.
        arm(0);
        expect_val("armed_after_enable", F_ARMED, 1);
        evq.push_back(EV_VOTE);
        press(0, 4'b0100, 15);
        idle(2);
        expect_val("armed_after_vote", F_ARMED, 0);
        expect_val("winner_c2", F_WIN, 2);
        expect_val("tie_c2", F_TIE, 0);

        // Short press (9 cycles) while armed -> nothing counted.
        arm(0);
        press(0, 4'b0010, 9);
        idle(3);
        expect_val("armed_after_short", F_ARMED, 1);
        // Results-mode pulse cancels the ballot.
        mode = 1'b1;
        idle(1);
        mode = 1'b0;
        idle(1);
        expect_val("armed_cancelled", F_ARMED, 0);
        // Valid press in IDLE -> reject, tallies unchanged.
        evq.push_back(EV_REJ);
        press(0, 4'b0010, 12);
        idle(3);
        expect_val("winner_after_idle_press", F_WIN, 2);
        expect_val("tie_after_idle_press", F_TIE, 0);

        // Simultaneous 0 and 3 -> candidate 0 counted, one reject.
        arm(0);
        evq.push_back(EV_REJ);
        evq.push_back(EV_VOTE);
        press(0, 4'b1001, 12);
        idle(6);
        expect_val("winner_0_2_tie", F_WIN, 0);
        expect_val("tie_0_2", F_TIE, 1);

        // Bring tallies to c0=1, c1=3, c2=3.
        vote(4'b0010);
        vote(4'b0010);
        vote(4'b0010);
        vote(4'b0100);
        vote(4'b0100);
        expect_val("winner_1_2_tie", F_WIN, 1);
        expect_val("tie_1_2", F_TIE, 1);
        vote(4'b0100);
        expect_val("winner_c2_lead", F_WIN, 2);
        expect_val("tie_c2_lead", F_TIE, 0);

        // Results display: c0=1, c1=3, c2=4, c3=0.
        mode = 1'b1;
        idle(2);
        expect_val("disp_default_sel0", F_LED, 1);
        press(0, 4'b0100, 12);
        idle(2);
        expect_val("disp_c2", F_LED, 4);
        press(0, 4'b1000, 12);
        idle(2);
        expect_val("disp_c3", F_LED, 0);
        press(0, 4'b0010, 12);
        idle(2);
        expect_val("disp_c1", F_LED, 3);
        expect_val("winner_in_results", F_WIN, 2);
        mode = 1'b0;
        idle(2);
        expect_val("led_voting_idle", F_LED, 0);

        // Reset during ACK: everything clears without a clock edge.
        arm(0);
        evq.push_back(EV_VOTE);
        button = 4'b0001;
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b1;
        expect_val("async_rst_led", F_LED, 0);
        expect_val("async_rst_armed", F_ARMED, 0);
        expect_val("async_rst_winner", F_WIN, 0);
        expect_val("async_rst_tie", F_TIE, 1);
        button = '0;
        idle(2);
        rst = 1'b0;
        idle(3);
        expect_val("post_rst_winner", F_WIN, 0);
        expect_val("post_rst_tie", F_TIE, 1);
        expect_val("post_rst_overflow", F_OV, 0);

        // Saturating instance (CNT_W=2): 3 votes fill, 4th overflows.
        s_vote();
        s_vote();
        s_vote();
        expect_val("sat_no_overflow_at_3", S_OV, 0);
        s_vote();
        expect_val("sat_overflow", S_OV, 1);
        expect_val("sat_winner", S_WIN, 0);
        expect_val("sat_tie", S_TIE, 0);
        s_mode = 1'b1;
        idle(1);
        press(1, 4'b0001, 5);
        idle(3);
        expect_val("sat_disp_c0", S_LED, 3);

        idle(4);
        done = 1'b1;
    end

endmodule
